instr_prefetch_queue: RTL and testbench
=======================================

// Module: instr_prefetch_queue
// PURPOSE
//  Decouples the core fetch stage from the instruction memory (fixed-latency, variable-latency or
//  cache build). Generates sequential fetch addresses, issues one read at a time using the memory's
//  Rd/Done handshake, and buffers returned instructions with their PCs in a DEPTH-entry FIFO.
//  Handles branch/jump redirects, including discarding a read already in flight, and stops fetching on halt (ecall).
// PARAMETERS
//  DEPTH     4      FIFO entries; power of two, >= 2
//  ADDR_W    32     PC / memory address width
//  RESET_PC  32'h0  first fetch address after reset
// PORTS
//  i_clk            in   1       clock, all state on rising edge
//  i_rst_n          in   1       synchronous reset, active-low
//  o_mem_rd         out  1       read request to instruction memory
//  o_mem_addr       out  ADDR_W  read address; stable while o_mem_rd=1
//  i_mem_data       in   32      read data, valid in the i_mem_done cycle
//  i_mem_done       in   1       one-cycle completion pulse for the outstanding read
//  o_instr_valid    out  1       FIFO head valid
//  o_instr          out  32      FIFO head instruction
//  o_instr_pc       out  ADDR_W  FIFO head PC
//  i_instr_ready    in   1       core consumes head when o_instr_valid && i_instr_ready
//  i_redirect       in   1       flush and restart fetch at i_redirect_pc
//  i_redirect_pc    in   ADDR_W  redirect target, word aligned
//  i_halt           in   1       level; while 1 no new reads are issued
// BEHAVIOUR
//  Reset (i_rst_n=0 at edge): state=IDLE, fetch_pc=RESET_PC, count=0, o_mem_rd=0, o_instr_valid=0.
//   Reset wins over all other inputs; an in-flight read is abandoned, and a later stray i_mem_done is ignored in IDLE.
//  FSM states: IDLE, WAIT, WAIT_DISCARD. o_mem_rd=1 exactly in WAIT and WAIT_DISCARD; o_mem_addr=req_addr reg.
//  IDLE -> WAIT when !i_halt && !i_redirect && count<DEPTH: req_addr<=fetch_pc.
//  WAIT + i_mem_done, no redirect: push {i_mem_data, req_addr}; fetch_pc<=req_addr+4; go IDLE.
//  WAIT + i_redirect (any i_mem_done): no push; fetch_pc<=i_redirect_pc;
//   ->IDLE if i_mem_done, else ->WAIT_DISCARD.
//  WAIT_DISCARD + i_mem_done: drop data, ->IDLE. Reads are never aborted; o_mem_rd, o_mem_addr held until done.
//  WAIT_DISCARD + i_redirect: fetch_pc<=new i_redirect_pc (latest redirect wins), stay until done.
//  IDLE + i_redirect: fetch_pc<=i_redirect_pc, no issue that cycle.
//  Redirect flushes FIFO the same edge: count<=0, pointers reset. A pop in that cycle is a don't-care (discarded).
//  Entries are reserved at issue: issue only if count<DEPTH, so a push never finds FIFO full.
//   Simultaneous push+pop: count unchanged.
//  FIFO is registered: data pushed at done edge is visible on o_instr_valid the next cycle (min 1-cycle bypassless latency).
//  Issue-to-issue minimum 2 cycles (IDLE visited between reads). With done in first WAIT cycle: 1 instr per 2 cycles.
//  i_halt only blocks IDLE->WAIT. An outstanding read completes and is pushed normally. FIFO keeps draining.
//  Address arithmetic modulo 2^ADDR_W: 32'hFFFF_FFFC + 4 wraps to 0. Low 2 bits of PCs are never altered.
//  Pointers wrap modulo DEPTH. count is clog2(DEPTH)+1 bits.
// TESTING
//  1 stream: done 1 cycle after rd, ready=1 -> PCs 0,4,8,C delivered in order with correct data, no gaps beyond 2-cycle cadence.
//  2 backpressure: ready=0, DEPTH=4 -> exactly 4 reads issued, o_mem_rd stays 0, valid=1 held.
//   Then ready=1 -> drains 0,4,8,C, fetch resumes at 0x10.
//  3 redirect in flight: done latency 5, redirect to 0x200 in 2nd WAIT cycle -> o_mem_rd held until done.
//   Data dropped, next o_mem_addr=0x200, first delivered PC=0x200.
//  4 redirect same cycle as done (and as pop) -> FIFO empty next cycle, no push, next read at target.
//  5 halt: assert i_halt mid-read -> that read pushed, no further o_mem_rd. Deassert -> resumes at next PC.
//  6 reset mid-WAIT and wrap: i_rst_n=0 during WAIT -> all outputs reset values next cycle.
//   Redirect to 0xFFFFFFFC -> PCs FFFFFFFC then 0.

Source files
------------

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue
//   Sequential instruction prefetcher between the core fetch stage and an
//   instruction memory using a one-outstanding Rd/Done handshake. Returned
//   instructions are buffered with their PCs in a DEPTH-entry FIFO.
//   Redirects flush the FIFO and restart fetch; a read already in flight is
//   allowed to complete and its data is dropped. i_halt blocks new issues.
// Ports
//   i_clk, i_rst_n                  clock, synchronous active-low reset
//   o_mem_rd/o_mem_addr             read request, held until i_mem_done
//   i_mem_data/i_mem_done           read data and one-cycle completion pulse
//   o_instr_valid/o_instr/o_instr_pc FIFO head
//   i_instr_ready                   head consumed when valid && ready
//   i_redirect/i_redirect_pc        flush and restart fetch at target
//   i_halt                          level, blocks issue of new reads
module instr_prefetch_queue #(
  parameter int              DEPTH    = 4,
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic              o_mem_rd,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [31:0]       i_mem_data,
  input  logic              i_mem_done,
  output logic              o_instr_valid,
  output logic [31:0]       o_instr,
  output logic [ADDR_W-1:0] o_instr_pc,
  input  logic              i_instr_ready,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  input  logic              i_halt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT, WAIT_DISCARD} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              push, pop;

  logic [31:0]       fifo_instr [DEPTH];
  logic [ADDR_W-1:0] fifo_pc    [DEPTH];

  assign o_mem_rd      = (state_q != IDLE);
  assign o_mem_addr    = req_addr_q;
  assign o_instr_valid = (count_q != '0);
  assign o_instr       = fifo_instr[rd_ptr_q];
  assign o_instr_pc    = fifo_pc[rd_ptr_q];
  assign pop           = o_instr_valid && i_instr_ready;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    push       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_redirect) begin
          fetch_pc_d = i_redirect_pc;
        end else if (!i_halt && (count_q < CNT_W'(DEPTH))) begin
          // Slot is reserved here, so the eventual push can never overflow.
          req_addr_d = fetch_pc_q;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (i_redirect) begin
          fetch_pc_d = i_redirect_pc;
          state_d    = i_mem_done ? IDLE : WAIT_DISCARD;
        end else if (i_mem_done) begin
          push       = 1'b1;
          fetch_pc_d = req_addr_q + ADDR_W'(4);
          state_d    = IDLE;
        end
      end
      WAIT_DISCARD: begin
        // Stale read still owns the bus; keep tracking the newest redirect.
        if (i_redirect) fetch_pc_d = i_redirect_pc;
        if (i_mem_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_redirect) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: count_q gates visibility of every entry.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_instr[wr_ptr_q] <= i_mem_data;
      fifo_pc[wr_ptr_q]    <= req_addr_q;
    end
  end
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Testbench for instr_prefetch_queue: cycle table for streaming/backpressure,
// directed sequences for redirect, halt, reset and address wrap.
// Memory model returns data = ~addr after 'lat' cycles of o_mem_rd.
module tb_instr_prefetch_queue;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_data = '0;
  logic        mem_done = 1'b0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        ready = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int wcnt = 0;

  instr_prefetch_queue #(.DEPTH(4), .ADDR_W(32), .RESET_PC(32'h0)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_mem_rd(mem_rd), .o_mem_addr(mem_addr),
    .i_mem_data(mem_data), .i_mem_done(mem_done),
    .o_instr_valid(instr_valid), .o_instr(instr), .o_instr_pc(instr_pc),
    .i_instr_ready(ready),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .i_halt(halt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        ready;
    logic        chk;
    logic        erd;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epc;
  } vec_t;

  vec_t tbl [30];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and drive the memory response for the
  // coming rising edge. Outputs are stable when this returns.
  task automatic step();
    @(negedge clk);
    if (mem_rd === 1'b1) begin
      wcnt++;
      if (wcnt >= lat) begin
        mem_done = 1'b1;
        mem_data = ~mem_addr;
        wcnt = 0;
      end else mem_done = 1'b0;
    end else begin
      wcnt = 0;
      mem_done = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect = 1'b0;
    halt = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_rd(input string name);
    int n = 0;
    while (mem_rd !== 1'b1 && n < 30) begin step(); n++; end
    if (mem_rd !== 1'b1) begin errors++; $display("FAIL %s: timeout waiting for o_mem_rd", name); end
  endtask

  // Step until an instruction is consumed; returns its PC and checks its data.
  task automatic next_instr(input string name, output logic [31:0] pc);
    int n = 0;
    pc = 'x;
    step();
    while (!(instr_valid === 1'b1 && ready) && n < 40) begin step(); n++; end
    if (instr_valid === 1'b1) begin
      pc = instr_pc;
      chk({name, "_data"}, instr, ~instr_pc);
    end else begin
      errors++;
      $display("FAIL %s: timeout waiting for o_instr_valid", name);
    end
  endtask

  initial begin
    logic [31:0] pc;
    int rd_cycles, delivered;
    logic bad_rd;

    // Test 1 (rows 0-10): streaming, lat=1, ready=1.
    // Test 2 (rows 11-29): backpressure fills 4 entries, then drains.
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h4};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h8,  1'b0, 32'h0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h8};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hC,  1'b0, 32'h0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'hC};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h0};
    tbl[16] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h4,  1'b1, 32'h0};
    tbl[17] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h0};
    tbl[18] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h8,  1'b1, 32'h0};
    tbl[19] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h0};
    tbl[20] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'hC,  1'b1, 32'h0};
    tbl[21] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h0};
    tbl[22] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h0};
    tbl[23] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h0};
    tbl[24] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h4};
    tbl[25] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8};
    tbl[26] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'hC};
    tbl[27] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h10};
    tbl[28] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h14};
    tbl[29] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h18, 1'b0, 32'h0};

    lat = 1;
    for (int i = 0; i < 30; i++) begin
      step();
      rst_n = tbl[i].rst_n;
      ready = tbl[i].ready;
      if (tbl[i].chk) begin
        chk($sformatf("row%0d_rd", i), {31'b0, mem_rd}, {31'b0, tbl[i].erd});
        chk($sformatf("row%0d_valid", i), {31'b0, instr_valid}, {31'b0, tbl[i].evalid});
        if (tbl[i].erd) chk($sformatf("row%0d_addr", i), mem_addr, tbl[i].eaddr);
        if (tbl[i].evalid) begin
          chk($sformatf("row%0d_pc", i), instr_pc, tbl[i].epc);
          chk($sformatf("row%0d_instr", i), instr, ~tbl[i].epc);
        end
      end
    end

    // Test 3: redirect in 2nd WAIT cycle of a 5-cycle read.
    lat = 5; ready = 1'b1;
    do_reset();
    wait_rd("t3_first_rd");
    step();
    redirect = 1'b1; redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    rd_cycles = 0;
    bad_rd = 1'b0;
    for (int n = 0; n < 12 && mem_rd === 1'b1; n++) begin
      if (mem_addr !== 32'h0 || instr_valid !== 1'b0) bad_rd = 1'b1;
      rd_cycles++;
      step();
    end
    chk("t3_held_cycles", rd_cycles, 3);
    chk("t3_addr_held", {31'b0, bad_rd}, 32'h0);
    chk("t3_valid_after_discard", {31'b0, instr_valid}, 32'h0);
    step();
    chk("t3_next_rd", {31'b0, mem_rd}, 32'h1);
    chk("t3_next_addr", mem_addr, 32'h200);
    next_instr("t3_first", pc);
    chk("t3_first_pc", pc, 32'h200);

    // Test 4: redirect on the same edge as done and pop.
    lat = 1; ready = 1'b0;
    do_reset();
    for (int n = 0; n < 30 && !(mem_rd === 1'b1 && instr_valid === 1'b1); n++) step();
    chk("t4_setup", {30'b0, mem_rd, mem_done}, 32'h3);
    ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
    step();
    redirect = 1'b0; ready = 1'b0;
    chk("t4_flushed", {31'b0, instr_valid}, 32'h0);
    chk("t4_idle", {31'b0, mem_rd}, 32'h0);
    step();
    chk("t4_next_addr", mem_addr, 32'h300);
    ready = 1'b1;
    next_instr("t4_first", pc);
    chk("t4_first_pc", pc, 32'h300);

    // Test 5: halt during an outstanding read.
    lat = 3; ready = 1'b1;
    do_reset();
    wait_rd("t5_first_rd");
    halt = 1'b1;
    delivered = 0;
    bad_rd = 1'b0;
    pc = 32'hDEAD;
    for (int n = 0; n < 12; n++) begin
      step();
      if (instr_valid === 1'b1) begin delivered++; pc = instr_pc; end
      if (delivered > 0 && mem_rd !== 1'b0) bad_rd = 1'b1;
    end
    chk("t5_delivered", delivered, 1);
    chk("t5_pc", pc, 32'h0);
    chk("t5_no_rd_when_halted", {31'b0, bad_rd}, 32'h0);
    halt = 1'b0;
    wait_rd("t5_resume");
    chk("t5_resume_addr", mem_addr, 32'h4);
    next_instr("t5_next", pc);
    chk("t5_next_pc", pc, 32'h4);

    // Test 6: reset mid-WAIT with a non-empty FIFO, then address wrap.
    lat = 1; ready = 1'b0;
    do_reset();
    for (int n = 0; n < 30 && instr_valid !== 1'b1; n++) step();
    lat = 5;
    wait_rd("t6_rd");
    chk("t6_pre_valid", {31'b0, instr_valid}, 32'h1);
    rst_n = 1'b0;
    step();
    chk("t6_rst_rd", {31'b0, mem_rd}, 32'h0);
    chk("t6_rst_valid", {31'b0, instr_valid}, 32'h0);
    rst_n = 1'b1;
    step();
    chk("t6_restart_rd", {31'b0, mem_rd}, 32'h1);
    chk("t6_restart_addr", mem_addr, 32'h0);
    lat = 1; ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    next_instr("t6_wrap0", pc);
    chk("t6_wrap0_pc", pc, 32'hFFFF_FFFC);
    next_instr("t6_wrap1", pc);
    chk("t6_wrap1_pc", pc, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
